// File: rtl/dma_hostrd_csr_responder.sv
// Host-read DMA dispatcher CSR block: DFH, descriptor staging,
// show-ahead command FIFO, IRQ and mover beat counters.
module dma_hostrd_csr_responder #(
  parameter int CMDQ_DEPTH            = 16,
  parameter int CMDQ_USEDW_WIDTH      = 8,
  parameter int HOST_MEM_ADDR_WIDTH   = 48,
  parameter int DEVICE_MEM_ADDR_WIDTH = 35,
  parameter int XFER_SIZE_WIDTH       = 40
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [7:0]                       mmio_address,
  input  logic                             mmio_write,
  input  logic                             mmio_read,
  input  logic [63:0]                      mmio_writedata,
  input  logic [7:0]                       mmio_byteenable,
  output logic [63:0]                      mmio_readdata,
  output logic                             mmio_readdatavalid,
  output logic                             mmio_waitrequest,
  output logic                             cmd_valid,
  input  logic                             cmd_ready,
  output logic [HOST_MEM_ADDR_WIDTH-1:0]   cmd_src,
  output logic [DEVICE_MEM_ADDR_WIDTH-1:0] cmd_dst,
  output logic [XFER_SIZE_WIDTH-1:0]       cmd_len,
  input  logic                             mover_busy,
  input  logic                             mover_done,
  input  logic                             mover_burst_pulse,
  input  logic [6:0]                       mover_burstcount,
  input  logic                             mover_rdvalid,
  input  logic                             mover_wrbeat,
  output logic                             mover_sclr,
  output logic                             irq
);

  localparam int AW = $clog2(CMDQ_DEPTH);
  localparam int HW = HOST_MEM_ADDR_WIDTH;
  localparam int DW = DEVICE_MEM_ADDR_WIDTH;
  localparam int XW = XFER_SIZE_WIDTH;

  typedef struct packed {
    logic [HW-1:0] src;
    logic [DW-1:0] dst;
    logic [XW-1:0] len;
  } desc_t;

  desc_t         mem [CMDQ_DEPTH];
  desc_t         head;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   used;
  logic [HW-1:0] src_q;
  logic [DW-1:0] dst_q;
  logic [63:0]   scratch_q;
  logic [63:0]   brst_q;
  logic [63:0]   rdv_q;
  logic [63:0]   wrb_q;
  logic [31:0]   done_q;
  logic          ovf_q;
  logic          full;
  logic          empty;
  logic          wr_ok;
  logic          wr_cfg;
  logic          wr_len;
  logic          sclr;
  logic          clr_irq;
  logic          irq_set;
  logic          push;
  logic          pop;
  logic [63:0]   rd_data;

  assign wr_ok   = mmio_write && (mmio_byteenable == 8'hFF);
  assign wr_cfg  = wr_ok && (mmio_address == 8'h15);
  assign wr_len  = wr_ok && (mmio_address == 8'h12);
  assign sclr    = wr_cfg && mmio_writedata[0];
  assign clr_irq = wr_cfg && mmio_writedata[1];

  assign used    = wr_ptr - rd_ptr;
  assign full    = (used == (AW+1)'(CMDQ_DEPTH));
  assign empty   = (used == '0);
  assign push    = wr_len && !full;
  assign pop     = cmd_valid && cmd_ready;
  // a mover completion with nothing left queued means the batch is done
  assign irq_set = mover_done && empty && !pop;

  assign mmio_waitrequest = 1'b0;
  assign cmd_valid = !empty;
  assign head      = mem[rd_ptr[AW-1:0]];
  assign cmd_src   = head.src;
  assign cmd_dst   = head.dst;
  assign cmd_len   = head.len;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= {src_q, dst_q, mmio_writedata[XW-1:0]};
  end

  always_comb begin
    rd_data = 64'h0BAD_0ADD_0BAD_0ADD;
    case (mmio_address)
      8'h00: rd_data = 64'h2000_0000_0800_0000;
      8'h01: rd_data = 64'h575F_BAB5_B61A_8DAE;
      8'h02: rd_data = 64'hBC24_AD4F_8738_F840;
      8'h03: rd_data = 64'h0000_0000_0001_0000;
      8'h05: rd_data = scratch_q;
      8'h10: rd_data = 64'(src_q);
      8'h11: rd_data = 64'(dst_q);
      8'h12: rd_data = '0;
      8'h13: begin
        rd_data = '0;
        rd_data[CMDQ_USEDW_WIDTH-1:0] = CMDQ_USEDW_WIDTH'(used);
        rd_data[8]  = full;
        rd_data[9]  = empty;
        rd_data[10] = ovf_q;
      end
      8'h14: rd_data = '0;
      8'h15: rd_data = '0;
      8'h16: rd_data = {61'h0, irq, 1'b0, mover_busy | !empty};
      8'h17: rd_data = brst_q;
      8'h18: rd_data = rdv_q;
      8'h19: rd_data = '0;
      8'h1A: rd_data = wrb_q;
      8'h1B: rd_data = 64'(done_q);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      src_q              <= '0;
      dst_q              <= '0;
      scratch_q          <= '0;
      brst_q             <= '0;
      rdv_q              <= '0;
      wrb_q              <= '0;
      done_q             <= '0;
      ovf_q              <= 1'b0;
      irq                <= 1'b0;
      mover_sclr         <= 1'b0;
      mmio_readdatavalid <= 1'b0;
      mmio_readdata      <= '0;
    end else begin
      if (wr_ok && mmio_address == 8'h10) src_q <= mmio_writedata[HW-1:0];
      if (wr_ok && mmio_address == 8'h11) dst_q <= mmio_writedata[DW-1:0];
      if (wr_ok && mmio_address == 8'h05) scratch_q <= mmio_writedata;
      if (sclr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        ovf_q  <= 1'b0;
        brst_q <= '0;
        rdv_q  <= '0;
        wrb_q  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        if (wr_len && full) ovf_q <= 1'b1;
        if (mover_burst_pulse) brst_q <= brst_q + 64'(mover_burstcount);
        if (mover_rdvalid) rdv_q <= rdv_q + 64'd1;
        if (mover_wrbeat) wrb_q <= wrb_q + 64'd1;
      end
      if (mover_done) done_q <= done_q + 32'd1;
      if (sclr) irq <= 1'b0;
      else if (irq_set) irq <= 1'b1;
      else if (clr_irq) irq <= 1'b0;
      mover_sclr         <= sclr;
      mmio_readdatavalid <= mmio_read;
      if (mmio_read) mmio_readdata <= rd_data;
    end
  end

endmodule

// File: tb/tb_dma_hostrd_csr_responder.sv
// Randomized bench for dma_hostrd_csr_responder against a
// queue-based behavioural model of the CSR map and FIFO.
module tb_dma_hostrd_csr_responder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  mmio_address = '0;
  logic        mmio_write = 1'b0;
  logic        mmio_read = 1'b0;
  logic [63:0] mmio_writedata = '0;
  logic [7:0]  mmio_byteenable = '0;
  logic [63:0] mmio_readdata;
  logic        mmio_readdatavalid;
  logic        mmio_waitrequest;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [47:0] cmd_src;
  logic [34:0] cmd_dst;
  logic [39:0] cmd_len;
  logic        mover_busy = 1'b0;
  logic        mover_done = 1'b0;
  logic        mover_burst_pulse = 1'b0;
  logic [6:0]  mover_burstcount = '0;
  logic        mover_rdvalid = 1'b0;
  logic        mover_wrbeat = 1'b0;
  logic        mover_sclr;
  logic        irq;

  always #5 clk = ~clk;

  dma_hostrd_csr_responder dut (
    .clk(clk), .reset_n(reset_n),
    .mmio_address(mmio_address), .mmio_write(mmio_write),
    .mmio_read(mmio_read), .mmio_writedata(mmio_writedata),
    .mmio_byteenable(mmio_byteenable),
    .mmio_readdata(mmio_readdata),
    .mmio_readdatavalid(mmio_readdatavalid),
    .mmio_waitrequest(mmio_waitrequest),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
    .mover_busy(mover_busy), .mover_done(mover_done),
    .mover_burst_pulse(mover_burst_pulse),
    .mover_burstcount(mover_burstcount),
    .mover_rdvalid(mover_rdvalid), .mover_wrbeat(mover_wrbeat),
    .mover_sclr(mover_sclr), .irq(irq)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [47:0] s;
    logic [34:0] d;
    logic [39:0] l;
  } desc_t;

  desc_t       m_q[$];
  logic [63:0] m_src, m_dst, m_scr, m_brst, m_rdv, m_wrb;
  logic [31:0] m_done;
  logic        m_ovf, m_irq, e_rdv, e_sclr;
  logic [63:0] e_rdata;
  logic [63:0] last_rd;

  function automatic void model_reset();
    m_q.delete();
    m_src = 0; m_dst = 0; m_scr = 0;
    m_brst = 0; m_rdv = 0; m_wrb = 0;
    m_done = 0; m_ovf = 0; m_irq = 0;
    e_rdv = 0; e_sclr = 0; e_rdata = 0;
  endfunction

  function automatic logic [63:0] m_read(logic [7:0] a);
    int n = m_q.size();
    case (a)
      8'h00: return 64'h2000_0000_0800_0000;
      8'h01: return 64'h575F_BAB5_B61A_8DAE;
      8'h02: return 64'hBC24_AD4F_8738_F840;
      8'h03: return 64'h10000;
      8'h05: return m_scr;
      8'h10: return m_src;
      8'h11: return m_dst;
      8'h13: return 64'(n) + (n == 16 ? 64'h100 : 0)
                    + (n == 0 ? 64'h200 : 0) + (m_ovf ? 64'h400 : 0);
      8'h14, 8'h15, 8'h19: return 0;
      8'h16: return ((mover_busy || n != 0) ? 64'd1 : 0)
                    + (m_irq ? 64'd4 : 0);
      8'h17: return m_brst;
      8'h18: return m_rdv;
      8'h1A: return m_wrb;
      8'h1B: return 64'(m_done);
      default: return 64'h0BAD_0ADD_0BAD_0ADD;
    endcase
  endfunction

  function automatic void model_step();
    logic [63:0] w = mmio_writedata;
    bit wok = mmio_write && mmio_byteenable == 8'hFF;
    bit cfg = wok && mmio_address == 8'h15;
    int n = m_q.size();
    bit sclr = cfg && w[0];
    bit popit = n > 0 && cmd_ready;
    bit pushit = 0;
    e_rdv = mmio_read;
    if (mmio_read) e_rdata = m_read(mmio_address);
    if (wok) begin
      case (mmio_address)
        8'h05: m_scr = w;
        8'h10: m_src = {16'h0, w[47:0]};
        8'h11: m_dst = {29'h0, w[34:0]};
        8'h12: if (n == 16) m_ovf = 1; else pushit = 1;
        default: ;
      endcase
    end
    if (mover_done && n == 0) m_irq = 1;
    else if (cfg && w[1]) m_irq = 0;
    if (mover_burst_pulse) m_brst += 64'(mover_burstcount);
    if (mover_rdvalid) m_rdv++;
    if (mover_wrbeat) m_wrb++;
    if (mover_done) m_done++;
    if (popit) void'(m_q.pop_front());
    if (pushit) m_q.push_back('{m_src[47:0], m_dst[34:0], w[39:0]});
    if (sclr) begin
      m_q.delete();
      m_brst = 0; m_rdv = 0; m_wrb = 0;
      m_ovf = 0; m_irq = 0;
    end
    e_sclr = sclr;
  endfunction

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    chk("rdvalid", 64'(mmio_readdatavalid), 64'(e_rdv));
    if (e_rdv) chk("rdata", mmio_readdata, e_rdata);
    chk("cmd_valid", 64'(cmd_valid), 64'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("cmd_src", 64'(cmd_src), 64'(m_q[0].s));
      chk("cmd_dst", 64'(cmd_dst), 64'(m_q[0].d));
      chk("cmd_len", 64'(cmd_len), 64'(m_q[0].l));
    end
    chk("irq", 64'(irq), 64'(m_irq));
    chk("sclr", 64'(mover_sclr), 64'(e_sclr));
    chk("waitreq", 64'(mmio_waitrequest), 64'd0);
    last_rd = mmio_readdata;
    @(negedge clk);
  endtask

  task automatic idle();
    mmio_write = 0; mmio_read = 0;
    mover_done = 0; mover_burst_pulse = 0;
    mover_rdvalid = 0; mover_wrbeat = 0;
  endtask

  task automatic wr(logic [7:0] a, logic [63:0] d);
    mmio_address = a; mmio_writedata = d;
    mmio_byteenable = 8'hFF; mmio_write = 1;
    step();
    mmio_write = 0;
  endtask

  task automatic rd(logic [7:0] a);
    mmio_address = a; mmio_read = 1;
    step();
    mmio_read = 0;
  endtask

  task automatic rand_inputs();
    logic [7:0] rl [16] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h05, 8'h10,
                           8'h11, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17,
                           8'h18, 8'h1A, 8'h1B, 8'h40};
    logic [7:0] wl [8] = '{8'h05, 8'h10, 8'h11, 8'h12,
                          8'h12, 8'h12, 8'h12, 8'h15};
    int r = $urandom_range(0, 9);
    mmio_read = 0; mmio_write = 0;
    if (r < 4) begin
      mmio_address = rl[$urandom_range(0, 15)];
      mmio_read = 1;
    end else if (r < 8) begin
      mmio_address = wl[$urandom_range(0, 7)];
      mmio_writedata = {$urandom, $urandom};
      if (mmio_address == 8'h15 && $urandom_range(0, 7) != 0)
        mmio_writedata[0] = 1'b0;
      mmio_byteenable = ($urandom_range(0, 7) == 0) ?
                        8'($urandom) : 8'hFF;
      mmio_write = 1;
    end
    cmd_ready = $urandom_range(0, 3) == 0;
    mover_done = $urandom_range(0, 7) == 0;
    mover_burst_pulse = $urandom_range(0, 3) == 0;
    mover_burstcount = 7'($urandom);
    mover_rdvalid = 1'($urandom);
    mover_wrbeat = 1'($urandom);
    mover_busy = 1'($urandom);
  endtask

  initial begin
    logic [7:0]  da [6] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h05, 8'h40};
    logic [63:0] dv [6] = '{64'h2000_0000_0800_0000,
                           64'h575F_BAB5_B61A_8DAE,
                           64'hBC24_AD4F_8738_F840,
                           64'h10000, 64'h0,
                           64'h0BAD_0ADD_0BAD_0ADD};
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1;
    chk("rst_cmd_valid", 64'(cmd_valid), 0);
    chk("rst_irq", 64'(irq), 0);
    chk("rst_sclr", 64'(mover_sclr), 0);
    chk("rst_rdvalid", 64'(mmio_readdatavalid), 0);
    chk("rst_rdata", mmio_readdata, 0);

    for (int i = 0; i < 6; i++) begin
      rd(da[i]);
      chk("dfh_read", last_rd, dv[i]);
    end

    wr(8'h10, 64'h1000);
    wr(8'h11, 64'h2000);
    wr(8'h12, 64'h4000);
    chk("push_src", 64'(cmd_src), 64'h1000);
    chk("push_dst", 64'(cmd_dst), 64'h2000);
    chk("push_len", 64'(cmd_len), 64'h4000);
    rd(8'h13);
    chk("cmdq_one", last_rd, 64'h001);

    for (int i = 1; i < 17; i++) begin
      wr(8'h10, 64'(i * 64'h100));
      wr(8'h12, 64'(i));
    end
    rd(8'h13);
    chk("cmdq_full_ovf", last_rd, 64'h510);
    cmd_ready = 1;
    repeat (17) step();
    cmd_ready = 0;
    rd(8'h13);
    chk("cmdq_drained", last_rd, 64'h600);

    mover_done = 1; step(); mover_done = 0;
    chk("irq_set", 64'(irq), 1);
    rd(8'h16);
    chk("status_irq", last_rd, 64'h4);
    wr(8'h15, 64'h2);
    chk("irq_clr", 64'(irq), 0);
    mover_done = 1; wr(8'h15, 64'h2); mover_done = 0;
    chk("irq_set_wins", 64'(irq), 1);
    wr(8'h15, 64'h2);

    mover_burstcount = 7'd4;
    mover_burst_pulse = 1; repeat (3) step();
    mover_burst_pulse = 0;
    mover_rdvalid = 1; mover_wrbeat = 1;
    repeat (12) step();
    idle();
    rd(8'h17); chk("brstcnt", last_rd, 64'd12);
    rd(8'h18); chk("rdvalid_cnt", last_rd, 64'd12);
    rd(8'h1A); chk("wrdata_cnt", last_rd, 64'd12);
    wr(8'h12, 64'h55);
    wr(8'h15, 64'h1);
    chk("sclr_pulse", 64'(mover_sclr), 1);
    step();
    chk("sclr_once", 64'(mover_sclr), 0);
    rd(8'h17); chk("brst_clr", last_rd, 0);
    rd(8'h13); chk("cmdq_clr", last_rd, 64'h200);

    for (int i = 0; i < 4000; i++) begin
      rand_inputs();
      step();
    end
    idle();
    cmd_ready = 0;
    mover_busy = 0;
    wr(8'h15, 64'h1);

    for (int i = 0; i < 5; i++) wr(8'h12, 64'(i + 7));
    chk("pre_rst_valid", 64'(cmd_valid), 1);
    #2;
    reset_n = 0;
    #1;
    chk("async_rst_valid", 64'(cmd_valid), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1;
    rd(8'h13);
    chk("post_rst_cmdq", last_rd, 64'h200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dma_hostrd_csr_responder.md
# dma_hostrd_csr_responder

MMIO64 register responder for the host-to-FPGA (host-read) half of the DMA dispatcher. Decodes host MMIO64 reads and writes to the DFH block (word addresses 0x00–0x06) and the host-read control block (0x10–0x1B). Queues {source, destination, length} descriptors into a 16-entry command FIFO that feeds the host-read data mover. Reports queue, mover, IRQ and beat-counter status back to the host.

## Interface
- CMDQ_DEPTH, 16, command FIFO depth in descriptors (power of two).
- CMDQ_USEDW_WIDTH, 8, width of the reported FIFO occupancy field.
- HOST_MEM_ADDR_WIDTH, 48, source (host) address width.
- DEVICE_MEM_ADDR_WIDTH, 35, destination (device) address width.
- XFER_SIZE_WIDTH, 40, transfer length width in bytes.
- clk  in  1  single clock for all logic.
- reset_n  in  1  asynchronous active-low reset.
- mmio_address  in  8  64-bit word address.
- mmio_write / mmio_read  in  1 each  request strobes; never asserted together.
- mmio_writedata  in  64  write data.
- mmio_byteenable  in  8  byte lanes; only 8'hFF writes take effect.
- mmio_readdata  out  64  read data.
- mmio_readdatavalid  out  1  read response strobe.
- mmio_waitrequest  out  1  tied 0.
- cmd_valid  out  1  descriptor at FIFO head is available.
- cmd_ready  in  1  mover accepts head descriptor.
- cmd_src / cmd_dst / cmd_len  out  48 / 35 / 40  head descriptor.
- mover_busy  in  1  mover has a transfer in flight.
- mover_done  in  1  one-cycle pulse when a transfer completes.
- mover_burst_pulse  in  1  one-cycle pulse per source read issued.
- mover_burstcount  in  7  burst length qualified by mover_burst_pulse.
- mover_rdvalid / mover_wrbeat  in  1 each  per-beat read-data and write-data strobes.
- mover_sclr  out  1  one-cycle soft clear to the mover.
- irq  out  1  level interrupt.

## Operation
- Registers: SRC 0x10, DST 0x11, LEN 0x12, CMDQ_STATUS 0x13, DATABUF_STATUS 0x14 (reads 0), CONFIG 0x15, STATUS 0x16, BRSTCNT 0x17, RDVALID 0x18, MAGICNUM 0x19 (reads 0), WRDATA 0x1A, STATUS2 0x1B.
- DFH block reads: 0x00 DFH header {FeatureType=2, rsvd 0, minor 0, rsvd 0, EOL 0, next offset 0x800, major 0, feature ID 0x000}; 0x01 ID_LO 64'h575F_BAB5_B61A_8DAE; 0x02 ID_HI 64'hBC24_AD4F_8738_F840; 0x03 next AFU offset 0x01_0000; 0x05 scratchpad (R/W, reset 0). Any unmapped address reads 64'h0BAD_0ADD_0BAD_0ADD; writes to it are ignored.
- SRC and DST are staging registers, R/W, truncated to their widths and zero-extended on read.
- A write to LEN pushes {SRC, DST, writedata[39:0]} into the FIFO.
  - If the FIFO is full: no push; OVERFLOW sticky bit is set.
  - Length 0 is pushed unchanged; the mover handles it.
- CMDQ_STATUS: [7:0] usedw, [8] full, [9] empty, [10] overflow.
- CONFIG write:
  - bit0 SCLR: flushes the FIFO, zeroes the three counters, clears overflow and irq, pulses mover_sclr for one cycle.
  - bit1 CLEAR_IRQ: clears irq.
  - CONFIG reads 0.
- STATUS: [0] rd_busy = mover_busy | ~empty; [1] wr_busy = 0; [2] irq.
- STATUS2: [31:0] completed-transfer count, wraps at 2^32.
- irq sets on mover_done when the FIFO is empty and no cmd_valid&&cmd_ready pop occurs that cycle. Set has priority over a same-cycle CLEAR_IRQ.
- Counters are 64 bits and wrap:
  - BRSTCNT += mover_burstcount on each mover_burst_pulse.
  - RDVALID += 1 per mover_rdvalid.
  - WRDATA += 1 per mover_wrbeat.

## Timing
- Reset values: all registers, counters and FIFO pointers are 0; irq=0, cmd_valid=0, mover_sclr=0, mmio_readdatavalid=0, mmio_readdata=0.
- Read latency is fixed at 1: a read sampled in cycle N gives readdatavalid=1 with data in N+1. One read outstanding per cycle; back-to-back reads are supported.
- Writes take effect at the clock edge where mmio_write=1. A read of the same register in the next cycle returns the new value.
- cmd_* is valid from the FIFO head (show-ahead). A pushed descriptor is visible on cmd_valid one cycle after the LEN write. A pop occurs when cmd_valid&&cmd_ready.
- Simultaneous push and pop on a full FIFO: the push is rejected as full and overflow is set. Simultaneous push and pop on an empty FIFO: the push is stored and no pop occurs.
- SCLR overrides a same-cycle push, pop and counter increment.
- Asynchronous reset mid-transfer discards queued descriptors immediately.

## Test plan
- Reset, then read 0x00–0x03, 0x05, 0x40 -> DFH header with next offset 0x800 in bits [39:16], IDs as specified, 0x10000, 0, 0x0BAD0ADD0BAD0ADD; each response exactly 1 cycle after its read.
- Write SRC=0x1000, DST=0x2000, LEN=0x4000 with cmd_ready=0 -> next cycle cmd_valid=1, cmd_src=0x1000, cmd_dst=0x2000, cmd_len=0x4000; CMDQ_STATUS=0x001.
- Issue 17 LEN writes with cmd_ready=0 -> usedw=16, full=1, overflow=1; draining with cmd_ready=1 returns all 16 in order.
- mover_done while the FIFO is empty -> irq=1 and STATUS[2]=1; CONFIG write 0x2 -> irq=0 next cycle; mover_done and CLEAR_IRQ in the same cycle -> irq stays 1.
- 3 burst pulses with burstcount 4, 12 rdvalid beats, 12 wrbeats -> BRSTCNT=12, RDVALID=12, WRDATA=12; CONFIG write 0x1 -> all 0, FIFO empty, mover_sclr high for exactly 1 cycle.
- Assert reset_n=0 asynchronously with 5 descriptors queued -> cmd_valid drops with no clock edge; after release usedw=0.
